// File: rtl/par_to_serial_tx.sv
// Parallel-in, serial-out transmitter, LSB first.
// SHIFT qualifies each bit; optional idle gap after every bit.
module par_to_serial_tx #(
  parameter int WIDTH   = 4,
  parameter int BIT_GAP = 0
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             LOAD,
  input  logic             ABORT,
  output logic             READY,
  output logic             SerialOut,
  output logic             SHIFT,
  output logic             DONE
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW =
    (BIT_GAP > 0) ? $clog2(BIT_GAP + 1) : 1;
  localparam logic [BW-1:0] LAST_BIT =
    BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_INIT =
    (BIT_GAP > 0) ? GW'(BIT_GAP - 1) : '0;
  localparam bit HAS_GAP = (BIT_GAP > 0);

  typedef enum logic [1:0] {
    IDLE,
    BIT,
    GAP
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic [BW-1:0]    bcnt, bcnt_d;
  logic [GW-1:0]    gcnt, gcnt_d;
  logic             last, last_d;
  logic             ser_d;
  logic             shift_d;
  logic             done_d;
  logic             ready_d;
  logic             bit_last;
  logic             gap_end;

  assign bit_last = (bcnt == LAST_BIT);
  assign gap_end  = (gcnt == '0);

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state     <= IDLE;
      sreg      <= '0;
      bcnt      <= '0;
      gcnt      <= '0;
      last      <= 1'b0;
      READY     <= 1'b1;
      SerialOut <= 1'b0;
      SHIFT     <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_d;
      sreg      <= sreg_d;
      bcnt      <= bcnt_d;
      gcnt      <= gcnt_d;
      last      <= last_d;
      READY     <= ready_d;
      SerialOut <= ser_d;
      SHIFT     <= shift_d;
      DONE      <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (LOAD && !ABORT)
          state_d = BIT;
      end
      BIT: begin
        if (ABORT)
          state_d = IDLE;
        else if (HAS_GAP)
          state_d = GAP;
        else if (bit_last)
          state_d = IDLE;
        else
          state_d = BIT;
      end
      GAP: begin
        if (ABORT)
          state_d = IDLE;
        else if (gap_end)
          state_d = last ? IDLE : BIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed one cycle early and registered.
  always_comb begin
    sreg_d  = sreg;
    bcnt_d  = bcnt;
    gcnt_d  = gcnt;
    last_d  = last;
    ser_d   = SerialOut;
    done_d  = 1'b0;
    ready_d = (state_d == IDLE);
    shift_d = (state_d == BIT);
    unique case (state)
      IDLE: begin
        if (LOAD && !ABORT) begin
          sreg_d = DataIn;
          bcnt_d = '0;
          gcnt_d = '0;
          last_d = 1'b0;
          ser_d  = DataIn[0];
        end
      end
      BIT: begin
        if (ABORT) begin
          bcnt_d = '0;
          gcnt_d = '0;
          last_d = 1'b0;
        end else begin
          sreg_d = sreg >> 1;
          bcnt_d = bit_last ? '0 : bcnt + BW'(1);
          if (HAS_GAP) begin
            gcnt_d = GAP_INIT;
            last_d = bit_last;
          end else if (bit_last) begin
            done_d = 1'b1;
          end else begin
            ser_d = sreg[1];
          end
        end
      end
      GAP: begin
        if (ABORT) begin
          bcnt_d = '0;
          gcnt_d = '0;
          last_d = 1'b0;
        end else if (!gap_end) begin
          gcnt_d = gcnt - GW'(1);
        end else if (last) begin
          last_d = 1'b0;
          done_d = 1'b1;
        end else begin
          ser_d = sreg[0];
        end
      end
      default: begin
        bcnt_d = '0;
        gcnt_d = '0;
        last_d = 1'b0;
      end
    endcase
  end

endmodule
